// File: rtl/uart_brg_if.sv
// UART baud rate generator bus bundle.
// SFR-side controls in, shifter strobes out.
interface uart_brg_if #(
  parameter int DIV_W = 8
);
  logic             en;
  logic             sync;
  logic             brgh;
  logic             spbrg_reg_wr_en;
  logic [DIV_W-1:0] spbrg_reg_in;
  logic [DIV_W-1:0] spbrg_reg_out;
  logic             rx_resync;
  logic             uart_tx_shift_en;
  logic             uart_rx_sample_en;
  logic             uart_rx_mid_en;

  modport master (
    output en, sync, brgh,
    output spbrg_reg_wr_en, spbrg_reg_in,
    output rx_resync,
    input  spbrg_reg_out,
    input  uart_tx_shift_en,
    input  uart_rx_sample_en,
    input  uart_rx_mid_en
  );

  modport slave (
    input  en, sync, brgh,
    input  spbrg_reg_wr_en, spbrg_reg_in,
    input  rx_resync,
    output spbrg_reg_out,
    output uart_tx_shift_en,
    output uart_rx_sample_en,
    output uart_rx_mid_en
  );
endinterface

// File: rtl/uart_brg.sv
// UART baud rate generator: sub -> div -> phase chain
// with 16x rx oversample and mid-bit strobe.
module uart_brg #(
  parameter int DIV_W = 8
) (
  input logic     clk,
  input logic     rst,
  uart_brg_if.slave bus
);

  logic [DIV_W-1:0] spbrg_q, spbrg_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       sub_q, sub_d;
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       phase_q, phase_d;
  logic [1:0]       sub_max;
  logic             sub_wrap;
  logic             div_wrap;
  logic             clr;
  logic             sample;

  // Terminal-count decode; high-speed async has no prescaler.
  always_comb begin
    sub_max  = (!bus.sync && bus.brgh) ? 2'd0 : 2'd3;
    sub_wrap = (sub_q == sub_max);
    div_wrap = sub_wrap && (div_q == spbrg_q);
    mode_d   = {bus.sync, bus.brgh};
    clr      = bus.spbrg_reg_wr_en
             | (mode_d != mode_q)
             | bus.rx_resync;
    spbrg_d  = bus.spbrg_reg_wr_en ? bus.spbrg_reg_in
                                   : spbrg_q;
  end

  // Counter next state: disable, then clear, then count.
  always_comb begin
    sub_d   = sub_q;
    div_d   = div_q;
    phase_d = phase_q;
    if (!bus.en || clr) begin
      sub_d   = '0;
      div_d   = '0;
      phase_d = '0;
    end else begin
      sub_d = sub_wrap ? 2'd0 : sub_q + 2'd1;
      if (sub_wrap)
        div_d = div_wrap ? '0 : div_q + DIV_W'(1);
      if (bus.sync)
        phase_d = '0;
      else if (div_wrap)
        phase_d = phase_q + 4'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spbrg_q <= '0;
      div_q   <= '0;
      sub_q   <= '0;
      phase_q <= '0;
      mode_q  <= '0;
    end else begin
      spbrg_q <= spbrg_d;
      div_q   <= div_d;
      sub_q   <= sub_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
    end
  end

  // Strobes are pure decodes of the current count.
  always_comb begin
    sample = bus.en & ~bus.sync & div_wrap;
  end

  assign bus.uart_rx_sample_en = sample;
  assign bus.uart_rx_mid_en    = sample & (phase_q == 4'd7);
  assign bus.uart_tx_shift_en  = bus.sync
                               ? (bus.en & div_wrap)
                               : (sample & (phase_q == 4'hF));
  assign bus.spbrg_reg_out     = spbrg_q;

endmodule

// File: tb/tb_uart_brg.sv
// Directed self-checking bench for uart_brg.
// Table of mode/divisor vectors plus corner sequences.
module tb_uart_brg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_brg_if #(.DIV_W(8))  b();
  uart_brg_if #(.DIV_W(12)) b2();

  uart_brg #(.DIV_W(8)) dut (
    .clk(clk), .rst(rst), .bus(b.slave)
  );
  uart_brg #(.DIV_W(12)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave)
  );

  typedef struct {
    logic       sync;
    logic       brgh;
    logic [7:0] spbrg;
    int         first;
    int         per;
    int         ns;
    int         nm;
    int         fm;
  } vec_t;

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  task automatic do_write(input logic [7:0] v,
                          input logic s, input logic h);
    @(negedge clk);
    b.sync = s;
    b.brgh = h;
    b.spbrg_reg_in = v;
    b.spbrg_reg_wr_en = 1'b1;
    @(negedge clk);
    b.spbrg_reg_wr_en = 1'b0;
  endtask

  // c=0 is the current (already cleared) cycle.
  task automatic measure(input int budget,
                         output int first, output int per,
                         output int ns, output int nm,
                         output int fm);
    first = -1; per = -1; ns = 0; nm = 0; fm = -1;
    for (int c = 0; c < budget; c++) begin
      if (c > 0) @(negedge clk);
      if (b.uart_rx_mid_en && fm < 0) fm = c;
      if (first >= 0) begin
        ns += int'(b.uart_rx_sample_en);
        nm += int'(b.uart_rx_mid_en);
      end
      if (b.uart_tx_shift_en) begin
        if (first < 0) first = c;
        else begin
          per = c - first;
          break;
        end
      end
    end
  endtask

  task automatic run_chk(input string tag, input int ef,
                         input int ep, input int ens,
                         input int enm, input int efm);
    int f, p, s, m, fm;
    measure(3000, f, p, s, m, fm);
    chk({tag, "_first"}, f, ef);
    chk({tag, "_per"}, p, ep);
    chk({tag, "_samp"}, s, ens);
    chk({tag, "_mid"}, m, enm);
    chk({tag, "_fmid"}, fm, efm);
  endtask

  vec_t vt [8];
  int pulses;
  int f2;

  initial begin
    vt[0] = '{1'b0, 1'b0, 8'd0,  63,  64, 16, 1, 31};
    vt[1] = '{1'b0, 1'b0, 8'd1, 127, 128, 16, 1, 63};
    vt[2] = '{1'b0, 1'b1, 8'd1,  31,  32, 16, 1, 15};
    vt[3] = '{1'b0, 1'b1, 8'd0,  15,  16, 16, 1,  7};
    vt[4] = '{1'b1, 1'b0, 8'd2,  11,  12,  0, 0, -1};
    vt[5] = '{1'b1, 1'b1, 8'd2,  11,  12,  0, 0, -1};
    vt[6] = '{1'b0, 1'b0, 8'd3, 255, 256, 16, 1, 127};
    vt[7] = '{1'b0, 1'b1, 8'd15, 255, 256, 16, 1, 127};

    b.en = 1'b1; b.sync = 1'b0; b.brgh = 1'b0;
    b.spbrg_reg_wr_en = 1'b0; b.spbrg_reg_in = '0;
    b.rx_resync = 1'b0;
    b2.en = 1'b0; b2.sync = 1'b0; b2.brgh = 1'b0;
    b2.spbrg_reg_wr_en = 1'b0; b2.spbrg_reg_in = '0;
    b2.rx_resync = 1'b0;

    #12;
    chk("rst_pulses", int'({b.uart_tx_shift_en,
        b.uart_rx_sample_en, b.uart_rx_mid_en}), 0);
    chk("rst_spbrg", int'(b.spbrg_reg_out), 0);

    @(negedge clk);
    rst = 1'b1;
    run_chk("from_rst", 63, 64, 16, 1, 31);

    foreach (vt[i]) begin
      do_write(vt[i].spbrg, vt[i].sync, vt[i].brgh);
      chk($sformatf("v%0d_rdbk", i),
          int'(b.spbrg_reg_out), int'(vt[i].spbrg));
      run_chk($sformatf("v%0d", i), vt[i].first,
              vt[i].per, vt[i].ns, vt[i].nm, vt[i].fm);
    end

    do_write(8'd1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    b.brgh = 1'b1;
    @(negedge clk);
    run_chk("mode_chg", 31, 32, 16, 1, 15);

    do_write(8'd0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    b.rx_resync = 1'b1;
    @(negedge clk);
    b.rx_resync = 1'b0;
    run_chk("resync", 63, 64, 16, 1, 31);

    do_write(8'd0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    b.en = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      pulses += int'(b.uart_tx_shift_en)
              + int'(b.uart_rx_sample_en)
              + int'(b.uart_rx_mid_en);
      if (c == 4) b.spbrg_reg_wr_en = 1'b1;
      if (c == 4) b.spbrg_reg_in = 8'd5;
      if (c == 5) b.spbrg_reg_wr_en = 1'b0;
    end
    chk("en_low_pulses", pulses, 0);
    chk("en_low_wr", int'(b.spbrg_reg_out), 5);
    b.spbrg_reg_in = 8'd0;
    b.spbrg_reg_wr_en = 1'b1;
    @(negedge clk);
    b.spbrg_reg_wr_en = 1'b0;
    b.brgh = 1'b0;
    @(negedge clk);
    b.en = 1'b1;
    run_chk("en_rise", 63, 64, 16, 1, 31);

    do_write(8'd3, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_sub", int'(dut.sub_q), 0);
    chk("arst_div", int'(dut.div_q), 0);
    chk("arst_phase", int'(dut.phase_q), 0);
    chk("arst_spbrg", int'(b.spbrg_reg_out), 0);
    @(negedge clk);
    rst = 1'b1;

    @(negedge clk);
    b2.en = 1'b1;
    b2.brgh = 1'b1;
    b2.spbrg_reg_in = 12'hFFF;
    b2.spbrg_reg_wr_en = 1'b1;
    @(negedge clk);
    b2.spbrg_reg_wr_en = 1'b0;
    chk("w12_rdbk", int'(b2.spbrg_reg_out), 4095);
    f2 = -1;
    for (int c = 0; c < 70000; c++) begin
      if (c > 0) @(negedge clk);
      if (b2.uart_tx_shift_en) begin
        f2 = c;
        break;
      end
    end
    chk("w12_first", f2, 65535);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
